rgb_axis_frame_sink: RTL and testbench

AXI4-Stream video slave that terminates the 24-bit RGB stream produced by the video pipeline. Recovers pixel coordinates from SOF (tuser) and EOL (tlast), checks frame geometry against fixed image dimensions, and re-emits each accepted pixel with its x/y on a registered valid/ready port. Used by the BMP frame writer and by on-chip frame capture; counts completed frames and flags framing errors.

---
 rtl/rgb_axis_frame_sink.sv | 225 ++++++++++++++++++++++
 tb/tb_rgb_axis_frame_sink.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_axis_frame_sink.sv
// rgb_axis_frame_sink
// Terminates a 24-bit RGB AXI4-Stream video stream. It recovers the pixel x/y
// position from tuser (start of frame) and tlast (end of line), and checks the
// frame geometry against IMG_WIDTH x IMG_HEIGHT. Each accepted pixel is
// re-emitted with its coordinates through a single output register.
// Optional feature: define RGB_SINK_CHECKSUM_EN to build a per-frame 32-bit
// pixel sum on frame_checksum. When it is not defined, frame_checksum is tied to 0.
module rgb_axis_frame_sink #(
  parameter int DATA_WIDTH = 24,
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 300,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  rgb_s_axis_tvalid,
  output logic                  rgb_s_axis_tready,
  input  logic [DATA_WIDTH-1:0] rgb_s_axis_tdata,
  input  logic                  rgb_s_axis_tuser,
  input  logic                  rgb_s_axis_tlast,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic [CNT_WIDTH-1:0]  pix_x,
  output logic [CNT_WIDTH-1:0]  pix_y,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  err_sof,
  output logic                  err_early_eol,
  output logic                  err_late_eol,
  input  logic                  err_clr,
  output logic [31:0]           frame_checksum
);

  localparam logic [CNT_WIDTH-1:0] XMAX = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] YMAX = CNT_WIDTH'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_WAIT_SOF, S_ACTIVE, S_RESYNC} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic                   pv_q, pv_d;
  logic [DATA_WIDTH-1:0]  pd_q;
  logic [CNT_WIDTH-1:0]   px_q, py_q;
  logic                   psof_q, peol_q;
  logic                   done_q;
  logic [15:0]            fcnt_q;
  logic                   esof_q, eearly_q, elate_q;

  logic                   beat, take, lend, emit, done;
  logic                   set_sof, set_early, set_late;
  logic [CNT_WIDTH-1:0]   cur_x, cur_y;

  // The output register may take a new beat when it is empty or being drained.
  assign rgb_s_axis_tready = !pv_q || pix_ready;
  assign beat = rgb_s_axis_tvalid && rgb_s_axis_tready;

  // Next-state logic: position tracking, line/frame end handling and error detection.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    take      = 1'b0;
    lend      = 1'b0;
    emit      = 1'b0;
    done      = 1'b0;
    set_sof   = 1'b0;
    set_early = 1'b0;
    set_late  = 1'b0;
    cur_x     = x_q;
    cur_y     = y_q;

    case (state_q)
      S_WAIT_SOF: begin
        if (beat && rgb_s_axis_tuser) begin
          take  = 1'b1;
          cur_x = '0;
          cur_y = '0;
        end
      end
      S_ACTIVE: begin
        if (beat) begin
          take = 1'b1;
          if (rgb_s_axis_tuser && (x_q != '0 || y_q != '0)) begin
            set_sof = 1'b1;
            cur_x   = '0;
            cur_y   = '0;
          end
        end
      end
      S_RESYNC: begin
        if (beat) begin
          if (rgb_s_axis_tuser) begin
            set_sof = 1'b1;
            take    = 1'b1;
            cur_x   = '0;
            cur_y   = '0;
          end else if (rgb_s_axis_tlast) begin
            lend = 1'b1;
          end
        end
      end
      default: state_d = S_WAIT_SOF;
    endcase

    // An emitted pixel either advances x or closes the line (correctly or early).
    if (take) begin
      emit = 1'b1;
      if (cur_x == XMAX) begin
        if (rgb_s_axis_tlast) begin
          lend = 1'b1;
        end else begin
          set_late = 1'b1;
          x_d      = cur_x;
          y_d      = cur_y;
          state_d  = S_RESYNC;
        end
      end else if (rgb_s_axis_tlast) begin
        set_early = 1'b1;
        lend      = 1'b1;
      end else begin
        x_d     = cur_x + 1'b1;
        y_d     = cur_y;
        state_d = S_ACTIVE;
      end
    end

    if (lend) begin
      x_d = '0;
      if (cur_y == YMAX) begin
        done    = 1'b1;
        y_d     = '0;
        state_d = S_WAIT_SOF;
      end else begin
        y_d     = cur_y + 1'b1;
        state_d = S_ACTIVE;
      end
    end

    pv_d = emit ? 1'b1 : (pix_ready ? 1'b0 : pv_q);
  end

  // Control state, output pixel register, frame counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= S_WAIT_SOF;
      x_q      <= '0;
      y_q      <= '0;
      pv_q     <= 1'b0;
      pd_q     <= '0;
      px_q     <= '0;
      py_q     <= '0;
      psof_q   <= 1'b0;
      peol_q   <= 1'b0;
      done_q   <= 1'b0;
      fcnt_q   <= '0;
      esof_q   <= 1'b0;
      eearly_q <= 1'b0;
      elate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pv_q    <= pv_d;
      if (emit) begin
        pd_q   <= rgb_s_axis_tdata;
        px_q   <= cur_x;
        py_q   <= cur_y;
        psof_q <= (cur_x == '0) && (cur_y == '0);
        peol_q <= (cur_x == XMAX);
      end
      done_q <= done;
      if (done) fcnt_q <= fcnt_q + 16'd1;
      if (set_sof)        esof_q   <= 1'b1;
      else if (err_clr)   esof_q   <= 1'b0;
      if (set_early)      eearly_q <= 1'b1;
      else if (err_clr)   eearly_q <= 1'b0;
      if (set_late)       elate_q  <= 1'b1;
      else if (err_clr)   elate_q  <= 1'b0;
    end
  end

`ifdef RGB_SINK_CHECKSUM_EN
  logic [31:0] sum_q, sum_d, csum_q;

  // The running sum restarts on every pixel emitted at (0,0).
  always_comb begin
    sum_d = sum_q;
    if (emit) begin
      if (cur_x == '0 && cur_y == '0) sum_d = 32'(rgb_s_axis_tdata);
      else                            sum_d = sum_q + 32'(rgb_s_axis_tdata);
    end
  end

  // The accumulator and the latched per-frame checksum.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sum_q  <= '0;
      csum_q <= '0;
    end else begin
      sum_q <= sum_d;
      if (done) csum_q <= sum_d;
    end
  end

  assign frame_checksum = csum_q;
`else
  assign frame_checksum = 32'd0;
`endif

  assign pix_valid     = pv_q;
  assign pix_data      = pd_q;
  assign pix_x         = px_q;
  assign pix_y         = py_q;
  assign pix_sof       = psof_q;
  assign pix_eol       = peol_q;
  assign frame_done    = done_q;
  assign frame_cnt     = fcnt_q;
  assign err_sof       = esof_q;
  assign err_early_eol = eearly_q;
  assign err_late_eol  = elate_q;

endmodule

// File: tb/tb_rgb_axis_frame_sink.sv
// Directed testbench for rgb_axis_frame_sink. It uses a 4x3 image geometry.
module tb_rgb_axis_frame_sink;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [23:0] tdata = '0;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [23:0] pix_data;
  logic [11:0] pix_x, pix_y;
  logic        pix_sof, pix_eol, frame_done;
  logic [15:0] frame_cnt;
  logic        err_sof, err_early_eol, err_late_eol;
  logic        err_clr = 1'b0;
  logic [31:0] frame_checksum;

  int total = 0;
  int bad = 0;

  logic [49:0] q[$];
  int          done_cnt = 0;
  logic [24:0] done_vec = '0;
  int          tready_viol = 0;
  int          hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [49:0] prev_vec = '0;

  rgb_axis_frame_sink #(
    .DATA_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(3), .CNT_WIDTH(12)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .rgb_s_axis_tvalid(tvalid), .rgb_s_axis_tready(tready),
    .rgb_s_axis_tdata(tdata), .rgb_s_axis_tuser(tuser), .rgb_s_axis_tlast(tlast),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_sof(err_sof), .err_early_eol(err_early_eol), .err_late_eol(err_late_eol),
    .err_clr(err_clr), .frame_checksum(frame_checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cs(input logic [31:0] v);
`ifdef RGB_SINK_CHECKSUM_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [49:0] pk(input int d, input int x, input int y,
                                     input logic s, input logic e);
    return {24'(d), 12'(x), 12'(y), s, e};
  endfunction

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_l) begin
      if (pix_valid && pix_ready) q.push_back({pix_data, pix_x, pix_y, pix_sof, pix_eol});
      if (frame_done) begin
        done_cnt++;
        done_vec = {pix_valid, pix_x, pix_y};
      end
      if (tready !== (!pix_valid || pix_ready)) tready_viol++;
      if (prev_stall && (!pix_valid || {pix_data, pix_x, pix_y, pix_sof, pix_eol} !== prev_vec))
        hold_viol++;
      prev_stall = pix_valid && !pix_ready;
      prev_vec = {pix_data, pix_x, pix_y, pix_sof, pix_eol};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset();
    rst_l = 1'b0;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; err_clr = 1'b0; pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    done_cnt = 0; done_vec = '0; tready_viol = 0; hold_viol = 0;
    rst_l = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input int d, input logic u, input logic l);
    logic acc;
    tvalid = 1'b1; tdata = 24'(d); tuser = u; tlast = l;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL beat_timeout data=%0d not accepted within 20 cycles", d);
    end
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < 12; i++) send_beat(base + i, i == 0, (i % 4) == 3);
  endtask

  task automatic drain();
    pix_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pix_valid got=%b want=0", pix_valid); end
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL rst_tready got=%b want=1", tready); end
    total++; if ({pix_data, pix_x, pix_y, pix_sof, pix_eol} !== 50'd0) begin bad++;
      $display("FAIL rst_pix_fields got=%h want=0", {pix_data, pix_x, pix_y, pix_sof, pix_eol}); end
    total++; if ({frame_done, frame_cnt, err_sof, err_early_eol, err_late_eol} !== 20'd0) begin bad++;
      $display("FAIL rst_status got=%h want=0", {frame_done, frame_cnt, err_sof, err_early_eol, err_late_eol}); end
    total++; if (frame_checksum !== 32'd0) begin bad++; $display("FAIL rst_checksum got=%0d want=0", frame_checksum); end
  endtask

  task automatic test_frame();
    do_reset();
    send_frame(1);
    drain();
    total++; if (q.size() != 12) begin bad++; $display("FAIL frame_count got=%0d want=12", q.size()); end
    for (int i = 0; i < 12 && i < q.size(); i++) begin
      total++;
      if (q[i] !== pk(i + 1, i % 4, i / 4, i == 0, (i % 4) == 3)) begin bad++;
        $display("FAIL frame_pix%0d got=%h want=%h", i, q[i], pk(i + 1, i % 4, i / 4, i == 0, (i % 4) == 3)); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL frame_done_pulses got=%0d want=1", done_cnt); end
    total++; if (done_vec !== {1'b1, 12'd3, 12'd2}) begin bad++;
      $display("FAIL frame_done_align got=%h want=%h", done_vec, {1'b1, 12'd3, 12'd2}); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL frame_cnt got=%0d want=1", frame_cnt); end
    total++; if ({err_sof, err_early_eol, err_late_eol} !== 3'b000) begin bad++;
      $display("FAIL frame_errs got=%b want=000", {err_sof, err_early_eol, err_late_eol}); end
    total++; if (frame_checksum !== exp_cs(32'd78)) begin bad++;
      $display("FAIL frame_checksum got=%0d want=%0d", frame_checksum, exp_cs(32'd78)); end
  endtask

  task automatic test_ready_toggle();
    logic stop;
    do_reset();
    stop = 1'b0;
    fork
      begin send_frame(1); stop = 1'b1; end
      begin
        while (!stop) begin
          pix_ready = ~pix_ready;
          @(posedge clk); #1;
        end
      end
    join
    drain();
    total++; if (q.size() != 12) begin bad++; $display("FAIL tog_count got=%0d want=12", q.size()); end
    for (int i = 0; i < 12 && i < q.size(); i++) begin
      total++;
      if (q[i] !== pk(i + 1, i % 4, i / 4, i == 0, (i % 4) == 3)) begin bad++;
        $display("FAIL tog_pix%0d got=%h want=%h", i, q[i], pk(i + 1, i % 4, i / 4, i == 0, (i % 4) == 3)); end
    end
    total++; if (tready_viol != 0) begin bad++; $display("FAIL tog_tready violations got=%0d want=0", tready_viol); end
    total++; if (hold_viol != 0) begin bad++; $display("FAIL tog_hold violations got=%0d want=0", hold_viol); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL tog_frame_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_no_sof();
    do_reset();
    for (int i = 0; i < 3; i++) send_beat(100 + i, 1'b0, 1'b0);
    send_frame(1);
    drain();
    total++; if (q.size() != 12) begin bad++; $display("FAIL nosof_count got=%0d want=12", q.size()); end
    total++; if (q.size() == 0 || q[0] !== pk(1, 0, 0, 1'b1, 1'b0)) begin bad++;
      $display("FAIL nosof_first got=%h want=%h", (q.size() > 0) ? q[0] : 50'd0, pk(1, 0, 0, 1'b1, 1'b0)); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL nosof_frame_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_early_eol();
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(1 + i, i == 0, i == 3);
    for (int i = 0; i < 3; i++) send_beat(5 + i, 1'b0, i == 2);
    for (int i = 0; i < 4; i++) send_beat(8 + i, 1'b0, i == 3);
    drain();
    total++; if (q.size() != 11) begin bad++; $display("FAIL early_count got=%0d want=11", q.size()); end
    total++; if (q.size() < 8 || q[6] !== pk(7, 2, 1, 1'b0, 1'b0) || q[7] !== pk(8, 0, 2, 1'b0, 1'b0)) begin bad++;
      $display("FAIL early_pix got=%h/%h want=%h/%h", (q.size() > 7) ? q[6] : 50'd0,
               (q.size() > 7) ? q[7] : 50'd0, pk(7, 2, 1, 1'b0, 1'b0), pk(8, 0, 2, 1'b0, 1'b0)); end
    total++; if ({err_sof, err_early_eol, err_late_eol} !== 3'b010) begin bad++;
      $display("FAIL early_errs got=%b want=010", {err_sof, err_early_eol, err_late_eol}); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL early_frame_cnt got=%0d want=1", frame_cnt); end
    total++; if (frame_checksum !== exp_cs(32'd66)) begin bad++;
      $display("FAIL early_checksum got=%0d want=%0d", frame_checksum, exp_cs(32'd66)); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    total++; if (err_early_eol !== 1'b0) begin bad++; $display("FAIL early_clr got=%b want=0", err_early_eol); end
  endtask

  task automatic test_late_eol();
    do_reset();
    for (int i = 0; i < 6; i++) send_beat(1 + i, i == 0, i == 5);
    for (int i = 0; i < 4; i++) send_beat(7 + i, 1'b0, i == 3);
    for (int i = 0; i < 4; i++) send_beat(11 + i, 1'b0, i == 3);
    drain();
    total++; if (q.size() != 12) begin bad++; $display("FAIL late_count got=%0d want=12", q.size()); end
    total++; if (q.size() < 5 || q[3] !== pk(4, 3, 0, 1'b0, 1'b1) || q[4] !== pk(7, 0, 1, 1'b0, 1'b0)) begin bad++;
      $display("FAIL late_pix got=%h/%h want=%h/%h", (q.size() > 4) ? q[3] : 50'd0,
               (q.size() > 4) ? q[4] : 50'd0, pk(4, 3, 0, 1'b0, 1'b1), pk(7, 0, 1, 1'b0, 1'b0)); end
    total++; if ({err_sof, err_early_eol, err_late_eol} !== 3'b001) begin bad++;
      $display("FAIL late_errs got=%b want=001", {err_sof, err_early_eol, err_late_eol}); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL late_frame_cnt got=%0d want=1", frame_cnt); end
    total++; if (frame_checksum !== exp_cs(32'd94)) begin bad++;
      $display("FAIL late_checksum got=%0d want=%0d", frame_checksum, exp_cs(32'd94)); end
  endtask

  task automatic test_sof_restart();
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(1 + i, i == 0, i == 3);
    send_beat(5, 1'b0, 1'b0);
    send_beat(6, 1'b0, 1'b0);
    send_beat(20, 1'b1, 1'b0);
    for (int i = 1; i < 12; i++) send_beat(20 + i, 1'b0, (i % 4) == 3);
    drain();
    total++; if (q.size() != 18) begin bad++; $display("FAIL sof_count got=%0d want=18", q.size()); end
    total++; if (q.size() < 18 || q[6] !== pk(20, 0, 0, 1'b1, 1'b0) || q[17] !== pk(31, 3, 2, 1'b0, 1'b1)) begin bad++;
      $display("FAIL sof_pix got=%h/%h want=%h/%h", (q.size() > 17) ? q[6] : 50'd0,
               (q.size() > 17) ? q[17] : 50'd0, pk(20, 0, 0, 1'b1, 1'b0), pk(31, 3, 2, 1'b0, 1'b1)); end
    total++; if (err_sof !== 1'b1) begin bad++; $display("FAIL sof_err got=%b want=1", err_sof); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL sof_frame_cnt got=%0d want=1", frame_cnt); end
    total++; if (frame_checksum !== exp_cs(32'd306)) begin bad++;
      $display("FAIL sof_checksum got=%0d want=%0d", frame_checksum, exp_cs(32'd306)); end
  endtask

  task automatic test_mid_reset();
    // err_sof and frame_cnt are nonzero from the previous test here.
    pix_ready = 1'b0;
    send_beat(50, 1'b1, 1'b0);
    total++; if (pix_valid !== 1'b1 || pix_data !== 24'd50) begin bad++;
      $display("FAIL mrst_pending got=%b/%0d want=1/50", pix_valid, pix_data); end
    #2;
    rst_l = 1'b0;
    #1;
    total++; if (pix_valid !== 1'b0 || pix_data !== 24'd0 || tready !== 1'b1) begin bad++;
      $display("FAIL mrst_outputs got=%b/%0d/%b want=0/0/1", pix_valid, pix_data, tready); end
    total++; if ({frame_cnt, err_sof, err_early_eol, err_late_eol} !== 19'd0 || frame_checksum !== 32'd0) begin bad++;
      $display("FAIL mrst_status got=%h/%0d want=0/0", {frame_cnt, err_sof, err_early_eol, err_late_eol}, frame_checksum); end
    @(posedge clk); #1;
    q.delete();
    rst_l = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    send_beat(60, 1'b0, 1'b0);
    send_beat(61, 1'b0, 1'b1);
    drain();
    total++; if (q.size() != 0) begin bad++; $display("FAIL mrst_needs_sof got=%0d pixels want=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ready_toggle();
    test_no_sof();
    test_early_eol();
    test_late_eol();
    test_sof_restart();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
